// File: rtl/display_scan_controller.sv
// Multiplexed 4-digit display scanner over a 16-digit BCD answer.
// A refresh divider steps a slot counter across four digit positions;
// select_code picks one of four 4-digit windows and optionally suppresses
// leading zeros. Any window change blanks the display for four slot ticks.
module display_scan_controller #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] answer_in,
    input  logic        answer_valid,
    output logic        answer_ready,
    input  logic [2:0]  select_code,
    output logic [3:0]  anode_n,
    output logic [3:0]  digit_bcd,
    output logic        digit_blank,
    output logic [3:0]  window_led
);

    localparam int unsigned DivW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [0:0] {StScan, StBlank} state_e;

    state_e          state_q, state_d;
    logic [DivW-1:0] div_cnt_q;
    logic [1:0]      slot_q;
    logic [1:0]      ticks_seen_q, ticks_seen_d;
    logic [63:0]     answer_reg_q;
    logic [2:0]      sel_reg_q;

    logic            tick;
    logic            frame_end;
    logic            sel_change;
    logic [3:0]      idx;
    logic [3:0]      digit;
    logic [3:0]      msd;
    logic            blanked;

    assign tick       = (div_cnt_q == DivW'(REFRESH_DIV - 1));
    assign frame_end  = tick && (slot_q == 2'd3);
    assign sel_change = (select_code != sel_reg_q);

    // Ready depends only on the frame timing, never on answer_valid.
    assign answer_ready = frame_end;

    // Refresh divider and slot counter run free in both FSM states.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
            slot_q    <= 2'd0;
        end else if (tick) begin
            div_cnt_q <= '0;
            slot_q    <= slot_q + 2'd1;
        end else begin
            div_cnt_q <= div_cnt_q + DivW'(1);
        end
    end

    // Answer is only taken at a frame boundary so a frame never mixes values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            answer_reg_q <= '0;
        end else if (frame_end && answer_valid) begin
            answer_reg_q <= answer_in;
        end
    end

    // Registered copy of select_code; outputs decode only from this copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_reg_q <= 3'd0;
        end else if (sel_change) begin
            sel_reg_q <= select_code;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StScan;
            ticks_seen_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            ticks_seen_q <= ticks_seen_d;
        end
    end

    // FSM next state: a select change (re)starts a four-tick blanking period.
    always_comb begin
        state_d      = state_q;
        ticks_seen_d = ticks_seen_q;
        if (sel_change) begin
            state_d      = StBlank;
            ticks_seen_d = 2'd0;
        end else if ((state_q == StBlank) && tick) begin
            if (ticks_seen_q == 2'd3) begin
                state_d      = StScan;
                ticks_seen_d = 2'd0;
            end else begin
                ticks_seen_d = ticks_seen_q + 2'd1;
            end
        end
    end

    // Index of the most significant nonzero digit (0 when all digits are zero).
    always_comb begin
        msd = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (answer_reg_q[4*k +: 4] != 4'd0) begin
                msd = 4'(k);
            end
        end
    end

    assign idx   = {sel_reg_q[1:0], slot_q};
    assign digit = answer_reg_q[{idx, 2'b00} +: 4];

    // Output decode for the current slot.
    always_comb begin
        blanked     = (state_q == StBlank) || (digit > 4'd9) || (sel_reg_q[2] && (idx > msd));
        anode_n     = 4'b1111;
        digit_bcd   = 4'h0;
        digit_blank = 1'b1;
        window_led  = 4'b0001 << sel_reg_q[1:0];
        if (!blanked) begin
            anode_n[slot_q] = 1'b0;
            digit_bcd       = digit;
            digit_blank     = 1'b0;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: directed scenarios with literal
// expectations, then randomized traffic against a cycle-count based model.
module tb_display_scan_controller;

    localparam int R = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] answer_in = '0;
    logic        answer_valid = 1'b0;
    logic [2:0]  select_code = 3'd0;
    logic        answer_ready;
    logic [3:0]  anode_n;
    logic [3:0]  digit_bcd;
    logic        digit_blank;
    logic [3:0]  window_led;

    int checks = 0;
    int errors = 0;

    // Model state: cycles since reset, displayed answer, window selection
    // and the cycle of the most recent selection change.
    int          m_n;
    logic [63:0] m_ans;
    logic [2:0]  m_sel;
    int          m_chg;
    bit          m_has_chg;

    display_scan_controller #(.REFRESH_DIV(R)) dut (
        .clk          (clk),
        .reset        (reset),
        .answer_in    (answer_in),
        .answer_valid (answer_valid),
        .answer_ready (answer_ready),
        .select_code  (select_code),
        .anode_n      (anode_n),
        .digit_bcd    (digit_bcd),
        .digit_blank  (digit_blank),
        .window_led   (window_led)
    );

    always #5 clk = ~clk;

    // Number of cycles k in [a,b] where a slot tick occurs (k % R == R-1).
    function automatic int ticks_in(int a, int b);
        if (b < a) return 0;
        return (b + 1) / R - a / R;
    endfunction

    function automatic logic [13:0] model_out();
        int          slot;
        int          idx;
        int          msd;
        logic [3:0]  d;
        logic [3:0]  an;
        logic [3:0]  bcd;
        logic [3:0]  led;
        logic        blk;
        logic        rdy;
        bit          blank_st;
        slot     = (m_n / R) % 4;
        blank_st = m_has_chg && (ticks_in(m_chg + 1, m_n - 1) < 4);
        idx      = 4 * int'(m_sel[1:0]) + slot;
        d        = m_ans[4*idx +: 4];
        msd      = 0;
        for (int k = 0; k < 16; k++) if (m_ans[4*k +: 4] != 4'd0) msd = k;
        an  = 4'b1111;
        bcd = 4'h0;
        blk = 1'b1;
        if (!(blank_st || d > 4'd9 || (m_sel[2] && idx > msd))) begin
            an[slot] = 1'b0;
            bcd      = d;
            blk      = 1'b0;
        end
        rdy = ((m_n % (4 * R)) == 4 * R - 1);
        led = 4'b0000;
        led[m_sel[1:0]] = 1'b1;
        return {an, bcd, blk, rdy, led};
    endfunction

    task automatic model_reset();
        m_n = 0; m_ans = '0; m_sel = 3'd0; m_chg = 0; m_has_chg = 0;
    endtask

    // Advance the model across one clock edge using the inputs the DUT sees.
    task automatic model_step();
        if (((m_n % (4 * R)) == 4 * R - 1) && answer_valid) m_ans = answer_in;
        if (select_code != m_sel) begin
            m_sel = select_code; m_chg = m_n; m_has_chg = 1;
        end
        m_n++;
    endtask

    task automatic check_model();
        logic [13:0] got;
        logic [13:0] exp;
        got = {anode_n, digit_bcd, digit_blank, answer_ready, window_led};
        exp = model_out();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL model cycle %0d: anode_n=%b digit_bcd=%h blank=%b ready=%b led=%b, required %b %h %b %b %b",
                     m_n, got[13:10], got[9:6], got[5], got[4], got[3:0],
                     exp[13:10], exp[9:6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    task automatic check_lit(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, required %h", name, m_n, got, exp);
        end
    endtask

    task automatic check_reset_vals(string name);
        check_lit({name, " anode_n"}, 32'(anode_n), 32'h0000_000E);
        check_lit({name, " digit_bcd"}, 32'(digit_bcd), 32'h0);
        check_lit({name, " digit_blank"}, 32'(digit_blank), 32'h0);
        check_lit({name, " answer_ready"}, 32'(answer_ready), 32'h0);
        check_lit({name, " window_led"}, 32'(window_led), 32'h0000_0001);
    endtask

    task automatic tick_one();
        if (!reset) model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic run_to(int target);
        while (m_n < target) tick_one();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_model();
        check_reset_vals("reset");
        tick_one();
        tick_one();
        select_code = 3'd0;
        reset = 1'b0;
    endtask

    function automatic logic [63:0] rand_answer();
        logic [63:0] a;
        int          len;
        a   = '0;
        len = $urandom_range(0, 16);
        for (int k = 0; k < 16; k++) begin
            if (k < len) begin
                if ($urandom_range(0, 7) == 0) a[4*k +: 4] = 4'($urandom_range(10, 15));
                else                          a[4*k +: 4] = 4'($urandom_range(0, 9));
            end
        end
        return a;
    endfunction

    initial begin
        model_reset();
        #2;
        do_reset();

        // Scan timing and first accepted answer.
        answer_in    = 64'h0000_0000_0012_3456;
        answer_valid = 1'b1;
        run_to(4);
        check_lit("slot1 anode_n", 32'(anode_n), 32'hD);
        run_to(14);
        check_lit("no ready at 14", 32'(answer_ready), 32'h0);
        run_to(15);
        check_lit("ready at 15", 32'(answer_ready), 32'h1);
        run_to(16);
        answer_valid = 1'b0;
        check_lit("ready low at 16", 32'(answer_ready), 32'h0);
        check_lit("slot0 digit", 32'(digit_bcd), 32'h6);
        run_to(20);
        check_lit("slot1 digit", 32'(digit_bcd), 32'h5);
        run_to(24);
        check_lit("slot2 digit", 32'(digit_bcd), 32'h4);
        run_to(28);
        check_lit("slot3 digit", 32'(digit_bcd), 32'h3);
        run_to(31);
        check_lit("ready at 31", 32'(answer_ready), 32'h1);

        // Window 1: blank for four ticks, then 2,1,0.
        run_to(32);
        select_code = 3'b001;
        run_to(47);
        check_lit("window1 blanking", 32'(anode_n), 32'hF);
        run_to(48);
        check_lit("window1 slot0 anode", 32'(anode_n), 32'hE);
        check_lit("window1 slot0 digit", 32'(digit_bcd), 32'h2);
        check_lit("window1 led", 32'(window_led), 32'h2);
        run_to(52);
        check_lit("window1 slot1 digit", 32'(digit_bcd), 32'h1);
        run_to(56);
        check_lit("window1 slot2 anode", 32'(anode_n), 32'hB);

        // Window 1 with zero suppression.
        run_to(64);
        select_code = 3'b101;
        run_to(80);
        check_lit("lz slot0 digit", 32'(digit_bcd), 32'h2);
        run_to(84);
        check_lit("lz slot1 digit", 32'(digit_bcd), 32'h1);
        run_to(88);
        check_lit("lz slot2 anode", 32'(anode_n), 32'hF);
        check_lit("lz slot2 blank", 32'(digit_blank), 32'h1);

        // All-zero answer with suppression: only slot 0 lit.
        answer_in    = '0;
        answer_valid = 1'b1;
        run_to(96);
        answer_valid = 1'b0;
        select_code  = 3'b100;
        run_to(112);
        check_lit("zero slot0 anode", 32'(anode_n), 32'hE);
        run_to(116);
        check_lit("zero slot1 anode", 32'(anode_n), 32'hF);

        // Non-BCD digit is blanked.
        answer_in    = 64'h0000_0000_0000_0A00;
        answer_valid = 1'b1;
        run_to(128);
        answer_valid = 1'b0;
        check_lit("hexA slot0 anode", 32'(anode_n), 32'hE);
        run_to(136);
        check_lit("hexA slot2 anode", 32'(anode_n), 32'hF);
        check_lit("hexA slot2 bcd", 32'(digit_bcd), 32'h0);

        // Rapid select changes keep the display blank; then reset mid-BLANK.
        for (int i = 0; i < 6; i++) begin
            select_code = select_code ^ 3'b001;
            run_to(m_n + 8);
            check_lit("held blank", 32'(anode_n), 32'hF);
        end
        answer_valid = 1'b1;
        answer_in    = 64'h9999;
        do_reset();
        answer_valid = 1'b0;
        run_to(16);
        check_lit("pending answer dropped", 32'(digit_bcd), 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) select_code = 3'($urandom);
            if ($urandom_range(0, 15) == 0) answer_in = rand_answer();
            answer_valid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 699) == 0) do_reset();
            tick_one();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
